// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: IF/ID stage register, fetch buffer entry and reset PC.
package rv32i_types;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    typedef struct packed {
        logic [31:0] pc_s;
        logic [31:0] pc_next_s;
        logic        valid_s;
    } if_id_stage_reg_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        done;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry circular buffer of fetch entries: allocate at tail, fill oldest pending,
// pop at head, flush everything.
module fetch_buffer
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_alloc,
    input  logic [31:0]   i_alloc_pc,
    input  logic          i_fill,
    input  logic [31:0]   i_fill_inst,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_pending,
    output logic          o_head_valid,
    output logic [31:0]   o_head_pc,
    output logic [31:0]   o_head_inst
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_fill;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_pending;

    // Responses arrive in request order, so done entries always form a prefix from the
    // head and the oldest pending entry is simply the next one after the last fill.
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_fill    <= '0;
            r_count   <= '0;
            r_pending <= '0;
        end else begin
            if (i_alloc) r_tail <= r_tail + PW'(1);
            if (i_pop)   r_head <= r_head + PW'(1);
            if (i_fill)  r_fill <= r_fill + PW'(1);
            r_count   <= r_count + CW'(i_alloc) - CW'(i_pop);
            r_pending <= r_pending + CW'(i_alloc) - CW'(i_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (!i_flush) begin
            if (i_alloc) begin
                r_mem[r_tail] <= '{pc: i_alloc_pc, inst: 32'h0, done: 1'b0};
            end
            if (i_fill) begin
                r_mem[r_fill].inst <= i_fill_inst;
                r_mem[r_fill].done <= 1'b1;
            end
        end
    end

    always_comb begin
        o_count      = r_count;
        o_pending    = r_pending;
        o_head_valid = (r_count != '0) && r_mem[r_head].done;
        o_head_pc    = r_mem[r_head].pc;
        o_head_inst  = r_mem[r_head].inst;
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: drives the PC, issues in-order imem reads, pairs responses with
// their PCs and presents one instruction per cycle to decode; handles stall and redirect.
module fetch_stage
    import rv32i_types::if_id_stage_reg_t;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = rv32i_types::RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic             imem_resp,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      inst,
    output if_id_stage_reg_t if_id_reg
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] w_discard_next;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_pending;
    logic          w_head_valid;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_inst;
    logic          w_full;
    logic          w_pop;
    logic          w_issue;
    logic          w_fill;

    assign w_full  = (w_count == CW'(DEPTH));
    assign w_pop   = rst && !redirect && w_head_valid && !stall;
    assign w_issue = rst && !redirect && (!w_full || w_pop);
    assign w_fill  = rst && !redirect && imem_resp && (r_discard == '0);

    // On redirect every in-flight request of the old stream becomes a discard; a response
    // landing in the redirect cycle itself retires one of them immediately.
    always_comb begin
        w_discard_next = r_discard;
        if (redirect) begin
            w_discard_next = r_discard + w_pending - CW'(imem_resp);
        end else if (imem_resp && (r_discard != '0)) begin
            w_discard_next = r_discard - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_discard <= '0;
        end else begin
            r_discard <= w_discard_next;
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (redirect),
        .i_alloc      (w_issue),
        .i_alloc_pc   (r_pc),
        .i_fill       (w_fill),
        .i_fill_inst  (imem_rdata),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_pending    (w_pending),
        .o_head_valid (w_head_valid),
        .o_head_pc    (w_head_pc),
        .o_head_inst  (w_head_inst)
    );

    always_comb begin
        imem_rmask = w_issue ? 4'hf : 4'h0;
        imem_addr  = r_pc;
        inst       = 32'h0;
        if_id_reg  = '0;
        if (rst) begin
            inst                = w_head_inst;
            if_id_reg.pc_s      = w_head_pc;
            if_id_reg.pc_next_s = w_head_pc + 32'd4;
            if_id_reg.valid_s   = w_head_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && imem_resp) begin
            assert (r_discard != '0 || w_pending != '0)
                else $error("imem response with no request outstanding");
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model with 1..3 cycle latency and a
// queue-based reference model of the fetch stream, plus directed literal checks.
module tb_fetch_stage;
    import rv32i_types::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h1eceb000;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      imem_addr;
    logic [3:0]       imem_rmask;
    logic             imem_resp;
    logic [31:0]      imem_rdata;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      inst;
    if_id_stage_reg_t if_id_reg;

    always #5 clk = ~clk;

    fetch_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_resp   (imem_resp),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .if_id_reg   (if_id_reg)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat_min = 1;
    int lat_max = 1;

    // Memory environment: requests seen on the bus and the cycle each response is due.
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    // Reference model: PCs already answered (presentable), PCs awaiting a response, and the
    // number of in-flight requests that belong to an abandoned stream.
    logic [31:0] m_pc;
    logic [31:0] m_done_q[$];
    logic [31:0] m_pend_q[$];
    int          m_stale;

    logic [3:0]  o_rmask;
    logic [31:0] o_addr;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_pcn;
    logic [31:0] o_inst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic bit resp_due();
        return mem_due_q.size() > 0 && mem_due_q[0] <= cyc;
    endfunction

    task automatic step(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
        logic        resp;
        logic [31:0] rdata;
        logic        e_valid;
        logic        e_pop;
        logic        e_issue;
        logic [31:0] p;
        int          due;
        @(negedge clk);
        if (!r) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end
        resp  = r && resp_due();
        rdata = resp ? mem_addr_q[0] : $urandom;
        rst         = r;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_resp   = resp;
        imem_rdata  = rdata;
        #1;
        o_rmask = imem_rmask;
        o_addr  = imem_addr;
        o_valid = if_id_reg.valid_s;
        o_pc    = if_id_reg.pc_s;
        o_pcn   = if_id_reg.pc_next_s;
        o_inst  = inst;
        if (!r) begin
            chk("rst_rmask", o_rmask, 4'h0);
            chk("rst_valid", o_valid, 1'b0);
            chk("rst_inst", o_inst, 32'h0);
            chk("rst_pc_s", o_pc, 32'h0);
            chk("rst_pc_next", o_pcn, 32'h0);
            m_pc    = RPC;
            m_stale = 0;
            m_done_q.delete();
            m_pend_q.delete();
        end else begin
            e_valid = m_done_q.size() > 0;
            e_pop   = e_valid && !st && !rd;
            e_issue = !rd && ((m_done_q.size() + m_pend_q.size() < DEPTH) || e_pop);
            chk("rmask", o_rmask, e_issue ? 4'hf : 4'h0);
            if (e_issue) chk("addr", o_addr, m_pc);
            chk("valid", o_valid, e_valid);
            if (e_valid) begin
                chk("pc_s", o_pc, m_done_q[0]);
                chk("pc_next", o_pcn, m_done_q[0] + 32'd4);
                chk("inst", o_inst, m_done_q[0]);
            end
            if (e_pop) void'(m_done_q.pop_front());
            if (resp) begin
                if (m_stale > 0) begin
                    m_stale--;
                end else if (m_pend_q.size() > 0) begin
                    p = m_pend_q.pop_front();
                    if (!rd) m_done_q.push_back(p);
                end
            end
            if (rd) begin
                m_stale += m_pend_q.size();
                m_pend_q.delete();
                m_done_q.delete();
                m_pc = rpc;
            end else if (e_issue) begin
                m_pend_q.push_back(m_pc);
                m_pc += 32'd4;
            end
        end
        if (resp) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (o_rmask == 4'hf) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (mem_due_q.size() > 0 && due <= mem_due_q[mem_due_q.size() - 1]) begin
                due = mem_due_q[mem_due_q.size() - 1] + 1;
            end
            mem_addr_q.push_back(o_addr);
            mem_due_q.push_back(due);
        end
        cyc++;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        int k = 0;
        do begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            k++;
        end while (!o_valid && k < 30);
        chk({name, "_seen"}, o_valid, 1'b1);
        if (o_valid) chk(name, o_pc, exp_pc);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_resp = 1'b0; imem_rdata = 32'h0;

        // Reset then single-cycle memory.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("first_rmask", o_rmask, 4'hf);
        chk("first_addr", o_addr, 32'h1eceb000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("second_addr", o_addr, 32'h1eceb004);
        chk("second_valid", o_valid, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("first_valid", o_valid, 1'b1);
        chk("first_pc", o_pc, 32'h1eceb000);
        chk("first_inst", o_inst, 32'h1eceb000);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("next_pc", o_pc, 32'h1eceb004);
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Stall for 5 cycles: buffer full, issue stops.
        repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_full_rmask", o_rmask, 4'h0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);

        // 3-cycle memory, then redirect with requests outstanding.
        lat_min = 3; lat_max = 3;
        repeat (20) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h1eceb100);
        wait_valid("redir_pc", 32'h1eceb100);
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect coincident with a response, then a second redirect before draining.
        for (int k = 0; k < 10 && !resp_due(); k++) step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h1eceb200);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h1eceb300);
        wait_valid("redir2_pc", 32'h1eceb300);

        // Reset mid-stream with a full buffer.
        lat_min = 1; lat_max = 1;
        repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_mid_valid", o_valid, 1'b0);
        chk("rst_mid_rmask", o_rmask, 4'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("restart_addr", o_addr, 32'h1eceb000);
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);

        // PC wrap.
        step(1'b1, 1'b0, 1'b1, 32'hfffffffc);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr0", o_addr, 32'hfffffffc);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_addr1", o_addr, 32'h00000000);
        wait_valid("wrap_pc", 32'hfffffffc);
        chk("wrap_pc_next", o_pcn, 32'h00000000);

        // Randomized traffic.
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        st;
            logic        rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) >= 1);
            st  = ($urandom_range(0, 99) < 30);
            rd  = ($urandom_range(0, 99) < 5);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hfffffff8 : ($urandom & 32'hfffffffc);
            step(r, st, rd, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
